// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple-borrow subtractor computing a - b - b_in one bit per clock
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [N-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic br, d, br_nx, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last = cnt == CW'(N - 1);
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // the minuend register doubles as the result register: consumed bits leave at
  // the LSB while difference bits enter at the MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      br <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      diff <= '0;
      b_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        br <= b_in;
        cnt <= '0;
      end else if (state == RUN) begin
        sa <= {d, sa[N-1:1]};
        sb <= sb >> 1;
        br <= br_nx;
        cnt <= last ? cnt : cnt + CW'(1);
        if (last) begin
          diff <= {d, sa[N-1:1]};
          b_out <= br_nx;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for N=4 and N=8 serial subtractors
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, bo4;
  logic [3:0] diff4;
  logic start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, bo8;
  logic [7:0] diff8;

  int checks = 0, errors = 0, dones4 = 0, dones8 = 0;
  logic [4:0] q4[$];
  logic [8:0] q8[$];

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .b_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bo4)
  );
  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse pops the oldest expected result
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      dones4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected actual=1 required=0");
      end else chk("result4", {27'd0, diff4, bo4}, {27'd0, q4.pop_front()});
    end
    if (done8 === 1'b1) begin
      dones8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected actual=1 required=0");
      end else chk("result8", {23'd0, diff8, bo8}, {23'd0, q8.pop_front()});
    end
  end

  // called at a negedge; drives a start for one edge and waits for done
  task automatic go(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bi,
                    input logic [7:0] ed, input logic eb);
    int lat, nb;
    bit seen;
    if (w8) begin
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      q8.push_back({ed, eb});
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; bin4 = bi; start4 = 1'b1;
      q4.push_back({ed[3:0], eb});
    end
    @(posedge clk);
    #1 start4 = 1'b0;
    start8 = 1'b0;
    lat = 0; nb = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (w8 ? done8 : done4) begin
        seen = 1'b1;
        lat = i;
      end else if (w8 ? busy8 : busy4) nb++;
    end
    chk(w8 ? "latency8" : "latency4", lat, w8 ? 9 : 5);
    chk(w8 ? "busy_cycles8" : "busy_cycles4", nb, w8 ? 8 : 4);
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1 chk("reset4", {25'd0, busy4, done4, diff4, bo4}, 0);
    chk("reset8", {21'd0, busy8, done8, diff8, bo8}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    go(0, 7, 3, 0, 4, 0);
    @(negedge clk);
    go(0, 3, 7, 0, 12, 1);
    @(negedge clk);
    go(0, 0, 0, 1, 15, 1);
    @(negedge clk);
    go(0, 10, 5, 1, 4, 0);
    go(0, 9, 9, 0, 0, 0);
    // second start and operand changes while busy must be ignored
    @(negedge clk);
    a4 = 12; b4 = 5; bin4 = 0; start4 = 1'b1;
    q4.push_back({4'd7, 1'b0});
    @(posedge clk);
    #1 start4 = 1'b0;
    d0 = dones4;
    repeat (2) @(negedge clk);
    a4 = 1; b4 = 2; bin4 = 1; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    a4 = 15; b4 = 0;
    repeat (15) @(negedge clk);
    chk("done_pulses4", dones4 - d0, 1);
    chk("busy_after4", {31'd0, busy4}, 0);
    chk("hold4", {27'd0, diff4, bo4}, {27'd0, 4'd7, 1'b0});
    // abort mid-operation
    a4 = 6; b4 = 1; bin4 = 0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_hidden4", {28'd0, diff4}, 7);
    rst_n = 1'b0;
    #1 chk("abort4", {25'd0, busy4, done4, diff4, bo4}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    d0 = dones4;
    repeat (10) @(negedge clk);
    chk("no_done_after_abort4", dones4 - d0, 0);
    go(0, 2, 5, 1, 12, 1);
    @(negedge clk);
    go(1, 200, 57, 0, 143, 0);
    @(negedge clk);
    go(1, 0, 255, 1, 0, 1);
    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
